// File: rtl/pipelined_alu_if.sv
// Operand/result bundle interface for the two-stage pipelined ALU.
// Handshake: a bundle moves across a channel on a rising clk edge where
// valid && ready are both 1. The producer holds valid and its data steady
// until that edge. The consumer may raise or drop ready freely.
// Here in_ready is a combinational function of out_ready.
interface pipelined_alu_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_output;
    logic [3:0]       flags;

    // Execute stage side: it supplies operands and consumes results.
    modport master (
        output in_valid, ALU_Control, A, B, out_ready,
        input  in_ready, out_valid, ALU_output, flags
    );

    // ALU side.
    modport slave (
        input  in_valid, ALU_Control, A, B, out_ready,
        output in_ready, out_valid, ALU_output, flags
    );
endinterface

// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with eight operations and registered {Z,N,C,V} flags.
// Stage 1 captures the operands and the opcode. Stage 2 captures the result and
// the flags. Each stage holds its contents while the stage after it is blocked.
module pipelined_alu #(
    parameter int WIDTH = 10,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    pipelined_alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    // Stage 1 registers
    logic             v1;
    alu_op_e          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2 registers
    logic             v2;
    logic [WIDTH-1:0] s2_res;
    logic [3:0]       s2_flags;

    // Combinational execute results from stage 1 contents
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;

    logic             s1_adv;
    logic             s2_adv;

    // S2 moves when it is empty or its result is being taken. S1 moves when
    // it is empty or S2 moves. There is no skid buffer, so in_ready follows
    // out_ready combinationally.
    assign s2_adv = !v2 || bus.out_ready;
    assign s1_adv = !v1 || s2_adv;

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = v2;
    assign bus.ALU_output = s2_res;
    assign bus.flags      = s2_flags;

    // Compute the result and flags of the bundle held in stage 1.
    always_comb begin
        sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
        diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
        shamt    = s1_b[SHW-1:0];
        res      = '0;
        flag_c   = 1'b0;
        flag_v   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res    = sum_ext[WIDTH-1:0];
                flag_c = sum_ext[WIDTH];
                // Overflow occurs when the operand signs agree and the result sign differs.
                flag_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                res    = diff_ext[WIDTH-1:0];
                // The extended top bit is set exactly when A < B unsigned (borrow).
                flag_c = diff_ext[WIDTH];
                flag_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                         (diff_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND: res = s1_a & s1_b;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SHL: res = (int'(shamt) >= WIDTH) ? '0 : (s1_a << shamt);
            OP_SHR: res = (int'(shamt) >= WIDTH) ? '0 : (s1_a >> shamt);
            default: res = '0;
        endcase
        flag_z = (res == '0);
        flag_n = res[WIDTH-1];
    end

    // Stage 1 operand register. It captures a new bundle whenever the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            s1_op <= OP_ADD;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (s1_adv) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op <= alu_op_e'(bus.ALU_Control);
                s1_a  <= bus.A;
                s1_b  <= bus.B;
            end
        end
    end

    // Stage 2 result register. The result and the flags always load together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_adv) begin
            v2 <= v1;
            if (v1) begin
                s2_res   <= res;
                s2_flags <= {flag_z, flag_n, flag_c, flag_v};
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu. A scoreboard queue holds expected
// {result, flags} entries. A monitor pops an entry on every output transfer
// and checks that held outputs stay stable while stalled.
module tb_pipelined_alu;
    localparam int WIDTH = 10;
    localparam int SHW   = $clog2(WIDTH);
    localparam int W     = WIDTH + 4;
    localparam int M     = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    pipelined_alu_if #(.WIDTH(WIDTH)) bus ();

    pipelined_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic logic [W-1:0] model(input int op, input int a, input int b);
        int r;
        int s;
        int amt;
        logic c;
        logic v;
        logic [WIDTH-1:0] rv;
        r = 0; c = 1'b0; v = 1'b0;
        amt = b % (1 << SHW);
        case (op)
            0: begin
                s = a + b; r = s % M; c = (s >= M);
                s = sgn(a) + sgn(b); v = (s > M / 2 - 1) || (s < -(M / 2));
            end
            1: begin
                r = (a - b + M) % M; c = (a < b);
                s = sgn(a) - sgn(b); v = (s > M / 2 - 1) || (s < -(M / 2));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sgn(a) < sgn(b)) ? 1 : 0;
            6: r = (amt >= WIDTH) ? 0 : ((a << amt) % M);
            7: r = (amt >= WIDTH) ? 0 : (a >> amt);
            default: r = 0;
        endcase
        rv = r[WIDTH-1:0];
        return {rv, (r == 0), (r >= M / 2), c, v};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = {bus.ALU_output, bus.flags};
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && bus.out_valid) begin
                checks++;
                if (got !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h required %h", got, prev_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL result: got %h required %h", got, exp);
                    end
                end
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= got;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1. Returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [W-1:0] exp,
                        output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        bus.in_valid    = 1'b1;
        bus.ALU_Control = op;
        bus.A           = a;
        bus.B           = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept required accept");
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic send_rand(output int stalls);
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op = 3'($urandom_range(0, 7));
        a  = WIDTH'($urandom_range(0, M - 1));
        b  = WIDTH'($urandom_range(0, M - 1));
        send(op, a, b, model(int'(op), int'(a), int'(b)), stalls);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.ALU_Control = 3'd0;
        bus.A           = '0;
        bus.B           = '0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        end
        checks++;
        if (bus.ALU_output !== '0) begin
            errors++; $display("FAIL reset_output: got %h required 000", bus.ALU_output);
        end
        checks++;
        if (bus.flags !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b required 0000", bus.flags);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int st;
        bus.out_ready = 1'b1;
        send(3'd0, 10'h0D7, 10'h02E, {10'h105, 4'b0000}, st);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: got %b required 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ALU_output !== 10'h105) begin
            errors++;
            $display("FAIL latency_result: got v=%b %h required v=1 105", bus.out_valid, bus.ALU_output);
        end
        wait_drain();
    endtask

    task automatic test_ops();
        int st;
        bus.out_ready = 1'b1;
        send(3'd0, 10'h3AE, 10'h33E, {10'h2EC, 4'b0110}, st);  // add with carry
        send(3'd0, 10'h1FF, 10'h001, {10'h200, 4'b0101}, st);  // add overflow
        send(3'd1, 10'h2AA, 10'h33E, {10'h36C, 4'b0110}, st);  // sub with borrow
        send(3'd1, 10'h155, 10'h155, {10'h000, 4'b1000}, st);  // sub to zero
        send(3'd2, 10'h3AE, 10'h13E, {10'h12E, 4'b0000}, st);  // and
        send(3'd3, 10'h0F0, 10'h30F, {10'h3FF, 4'b0100}, st);  // or
        send(3'd4, 10'h2AA, 10'h2AA, {10'h000, 4'b1000}, st);  // xor to zero
        send(3'd5, 10'h200, 10'h001, {10'h001, 4'b0000}, st);  // slt negative < positive
        send(3'd5, 10'h001, 10'h200, {10'h000, 4'b1000}, st);  // slt false
        send(3'd6, 10'h001, 10'd9,   {10'h200, 4'b0100}, st);  // shl to msb
        send(3'd6, 10'h001, 10'h012, {10'h004, 4'b0000}, st);  // shl ignores B upper bits
        send(3'd7, 10'h200, 10'd12,  {10'h000, 4'b1000}, st);  // shr amount >= WIDTH
        send(3'd7, 10'h200, 10'd9,   {10'h001, 4'b0000}, st);  // shr
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int st;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_rand(st);
            checks++;
            if (st != 0) begin
                errors++; $display("FAIL throughput_stall: got %0d required 0", st);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int st;
        int base;
        logic [W-1:0] held;
        base = n_out;
        bus.out_ready = 1'b0;
        send(3'd0, 10'h001, 10'h002, {10'h003, 4'b0000}, st);
        send(3'd0, 10'h010, 10'h020, {10'h030, 4'b0000}, st);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL full_in_ready: got %b required 0", bus.in_ready);
        end
        held = {bus.ALU_output, bus.flags};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.ALU_output, bus.flags} !== {10'h003, 4'b0000} ||
                {bus.ALU_output, bus.flags} !== held) begin
                errors++;
                $display("FAIL held_result: got v=%b %h required v=1 %h", bus.out_valid,
                         {bus.ALU_output, bus.flags}, {10'h003, 4'b0000});
            end
        end
        bus.out_ready = 1'b1;
        send(3'd0, 10'h100, 10'h200, {10'h300, 4'b0100}, st);
        checks++;
        if (st != 0) begin
            errors++; $display("FAIL release_accept: got %0d stalls required 0", st);
        end
        send(3'd0, 10'h3FF, 10'h001, {10'h000, 4'b1010}, st);
        wait_drain();
        checks++;
        if (n_out - base != 4) begin
            errors++; $display("FAIL out_count: got %0d required 4", n_out - base);
        end
    endtask

    task automatic test_random_stall();
        bit stream_done;
        int st;
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) send_rand(st);
                stream_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !stream_done; c++) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int st;
        bus.out_ready = 1'b0;
        send(3'd4, 10'h3C3, 10'h0FF, {10'h33C, 4'b0100}, st);
        send(3'd3, 10'h001, 10'h002, {10'h003, 4'b0000}, st);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid: got %b required 0", bus.out_valid);
        end
        checks++;
        if (bus.ALU_output !== '0 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_output: got %h %b required 000 0000", bus.ALU_output, bus.flags);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL stale_after_reset: got %b required 0", bus.out_valid);
            end
        end
        test_latency();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
